// File: rtl/dma_pkg.sv
// Shared constants and types for the 8237A-style DMA programming block.
package dma_pkg;

   localparam int NCH = 4;
   localparam int AW  = 16;

   localparam logic [3:0] REG_CMD     = 4'h8;
   localparam logic [3:0] REG_REQ     = 4'h9;
   localparam logic [3:0] REG_SMASK   = 4'hA;
   localparam logic [3:0] REG_MODE    = 4'hB;
   localparam logic [3:0] REG_CLRFF   = 4'hC;
   localparam logic [3:0] REG_MCLR    = 4'hD;
   localparam logic [3:0] REG_CLRMASK = 4'hE;
   localparam logic [3:0] REG_ALLMASK = 4'hF;

   // Mode byte bits 7:2, MSB first.
   typedef struct packed {
      logic [1:0] mode;
      logic       dec;
      logic       autoinit;
      logic [1:0] xfer;
   } modeFld_t;

endpackage

// File: rtl/dma_prog_regs_if.sv
// CPU program-cycle bus between the host and the DMA programming block.
interface dma_prog_regs_if;
   logic       CS_N;
   logic       IOR_N;
   logic       IOW_N;
   logic       HLDA;
   logic [3:0] A;
   logic [7:0] DB_in;
   logic [7:0] DB_out;
   logic       DB_oe;

   modport master (output CS_N, IOR_N, IOW_N, HLDA, A, DB_in, input DB_out, DB_oe);
   modport slave  (input CS_N, IOR_N, IOW_N, HLDA, A, DB_in, output DB_out, DB_oe);
endinterface

// File: rtl/dma_strobe_edge.sv
// Samples an active-low CPU strobe on clk, latches the payload while it is low,
// and pulses for one cycle on its trailing edge.
module dma_strobe_edge #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         strobeN,
   input  logic         en,
   input  logic         hold,
   input  logic [W-1:0] din,
   output logic         pulse,
   output logic [W-1:0] held
);

   logic active;

   // hold aborts an in-flight strobe; chip-select loss alone keeps the last latched payload.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active <= 1'b0;
         held   <= '0;
      end else if (hold || strobeN) begin
         active <= 1'b0;
      end else if (en) begin
         active <= 1'b1;
         held   <= din;
      end
   end

   assign pulse = active && strobeN && !hold;

endmodule

// File: rtl/dma_prog_regs.sv
// CPU-side register file of the DMA controller: program-cycle decode, byte
// pointer flip-flop, per-channel address/count, mode/command/request/mask/status.
module dma_prog_regs
   import dma_pkg::*;
#(
   parameter int NCH = dma_pkg::NCH,
   parameter int AW  = dma_pkg::AW
) (
   input  logic                    CLK,
   input  logic                    RESET,
   dma_prog_regs_if.slave          cpu,
   input  logic [NCH-1:0]          dreq_sts,
   input  logic [NCH-1:0]          tc_set,
   input  logic                    upd_en,
   input  logic [1:0]              upd_ch,
   input  logic [AW-1:0]           upd_addr,
   input  logic [AW-1:0]           upd_cnt,
   input  logic                    reload,
   output logic [NCH-1:0][AW-1:0]  cur_addr,
   output logic [NCH-1:0][AW-1:0]  cur_cnt,
   output logic [NCH-1:0][5:0]     modeReg,
   output logic [7:0]              commandReg,
   output logic [7:0]              requestReg,
   output logic [7:0]              maskReg,
   output logic [7:0]              statusReg
);

   logic pgm;
   logic wrPulse, rdPulse;
   logic [3:0] wA, rA;
   logic [7:0] wD;
   logic [1:0] wCh;

   logic                   byteFf, nFf;
   logic [7:0]             cmd, nCmd;
   logic [NCH-1:0]         req, nReq;
   logic [NCH-1:0]         msk, nMsk;
   logic [NCH-1:0]         tcf, nTcf;
   modeFld_t [NCH-1:0]     mode, nMode;
   logic [NCH-1:0][AW-1:0] baseA, nBaseA, baseC, nBaseC;
   logic [NCH-1:0][AW-1:0] curA, nCurA, curC, nCurC;
   logic                   mclr;

   assign pgm = !cpu.CS_N && !cpu.HLDA;

   dma_strobe_edge #(.W(12)) uWr (
      .clk(CLK), .rst(RESET), .strobeN(cpu.IOW_N), .en(pgm), .hold(cpu.HLDA),
      .din({cpu.A, cpu.DB_in}), .pulse(wrPulse), .held({wA, wD})
   );

   dma_strobe_edge #(.W(4)) uRd (
      .clk(CLK), .rst(RESET), .strobeN(cpu.IOR_N), .en(pgm), .hold(cpu.HLDA),
      .din(cpu.A), .pulse(rdPulse), .held(rA)
   );

   assign wCh = wA[2:1];

   always_comb begin
      nFf    = byteFf;
      nCmd   = cmd;
      nReq   = req;
      nMsk   = msk;
      nTcf   = tcf;
      nMode  = mode;
      nBaseA = baseA;
      nBaseC = baseC;
      nCurA  = curA;
      nCurC  = curC;
      mclr   = 1'b0;

      if (wrPulse) begin
         if (!wA[3]) begin
            if (!wA[0]) begin
               if (byteFf) begin
                  nBaseA[wCh][15:8] = wD;
                  nCurA[wCh][15:8]  = wD;
               end else begin
                  nBaseA[wCh][7:0] = wD;
                  nCurA[wCh][7:0]  = wD;
               end
            end else begin
               if (byteFf) begin
                  nBaseC[wCh][15:8] = wD;
                  nCurC[wCh][15:8]  = wD;
               end else begin
                  nBaseC[wCh][7:0] = wD;
                  nCurC[wCh][7:0]  = wD;
               end
            end
            nFf = !byteFf;
         end else begin
            case (wA)
               REG_CMD:     nCmd = wD;
               REG_REQ:     nReq[wD[1:0]] = wD[2];
               REG_SMASK:   nMsk[wD[1:0]] = wD[2];
               REG_MODE:    nMode[wD[1:0]] = modeFld_t'(wD[7:2]);
               REG_CLRFF:   nFf = 1'b0;
               REG_MCLR:    mclr = 1'b1;
               REG_CLRMASK: nMsk = '0;
               REG_ALLMASK: nMsk = wD[NCH-1:0];
               default:     ;
            endcase
         end
      end

      if (rdPulse) begin
         if (!rA[3])
            nFf = !nFf;
         else if (rA == REG_CMD)
            nTcf = '0;
      end

      if (reload) begin
         nCurA[upd_ch] = baseA[upd_ch];
         nCurC[upd_ch] = baseC[upd_ch];
      end else if (upd_en) begin
         nCurA[upd_ch] = upd_addr;
         nCurC[upd_ch] = upd_cnt;
      end

      // TC is applied after CPU status/mask/request effects so it wins those collisions.
      for (int c = 0; c < NCH; c++) begin
         if (tc_set[c]) begin
            nTcf[c] = 1'b1;
            nReq[c] = 1'b0;
            if (!mode[c].autoinit)
               nMsk[c] = 1'b1;
         end
      end

      if (mclr) begin
         nFf   = 1'b0;
         nCmd  = '0;
         nReq  = '0;
         nMsk  = '1;
         nTcf  = '0;
         nMode = '0;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         byteFf <= 1'b0;
         cmd    <= '0;
         req    <= '0;
         msk    <= '1;
         tcf    <= '0;
         mode   <= '0;
         baseA  <= '0;
         baseC  <= '0;
         curA   <= '0;
         curC   <= '0;
      end else begin
         byteFf <= nFf;
         cmd    <= nCmd;
         req    <= nReq;
         msk    <= nMsk;
         tcf    <= nTcf;
         mode   <= nMode;
         baseA  <= nBaseA;
         baseC  <= nBaseC;
         curA   <= nCurA;
         curC   <= nCurC;
      end
   end

   logic [AW-1:0] rdWord;
   logic [7:0]    dbOut;

   assign rdWord = cpu.A[0] ? curC[cpu.A[2:1]] : curA[cpu.A[2:1]];

   always_comb begin
      dbOut = '0;
      if (!cpu.A[3])
         dbOut = byteFf ? rdWord[15:8] : rdWord[7:0];
      else if (cpu.A == REG_CMD)
         dbOut = statusReg;
   end

   assign cpu.DB_out = dbOut;
   assign cpu.DB_oe  = pgm && !cpu.IOR_N;

   assign cur_addr   = curA;
   assign cur_cnt    = curC;
   assign modeReg    = mode;
   assign commandReg = cmd;
   assign requestReg = {{(8-NCH){1'b0}}, req};
   assign maskReg    = {{(8-NCH){1'b0}}, msk};
   assign statusReg  = {dreq_sts, tcf};

endmodule

// File: tb/tb_dma_prog_regs.sv
// Scoreboard bench for dma_prog_regs: stimulus queues expectations, a negedge
// monitor compares them as CPU reads or register probes appear.
module tb_dma_prog_regs;
   import dma_pkg::*;

   localparam int K_RD   = 0;
   localparam int K_MASK = 1;
   localparam int K_CMD  = 2;
   localparam int K_STS  = 3;
   localparam int K_REQ  = 4;
   localparam int K_OE   = 5;
   localparam int K_ADDR = 6;
   localparam int K_CNT  = 7;
   localparam int K_MODE = 8;
   localparam int K_QEND = 9;

   typedef struct {
      int          kind;
      int          ch;
      logic [15:0] exp;
   } exp_t;

   logic CLK, RESET;
   logic [3:0] dreq_sts, tc_set;
   logic upd_en, reload;
   logic [1:0] upd_ch;
   logic [15:0] upd_addr, upd_cnt;
   logic [3:0][15:0] cur_addr, cur_cnt;
   logic [3:0][5:0] modeReg;
   logic [7:0] commandReg, requestReg, maskReg, statusReg;

   dma_prog_regs_if cpu ();

   dma_prog_regs dut (
      .CLK(CLK), .RESET(RESET), .cpu(cpu),
      .dreq_sts(dreq_sts), .tc_set(tc_set),
      .upd_en(upd_en), .upd_ch(upd_ch), .upd_addr(upd_addr), .upd_cnt(upd_cnt),
      .reload(reload),
      .cur_addr(cur_addr), .cur_cnt(cur_cnt), .modeReg(modeReg),
      .commandReg(commandReg), .requestReg(requestReg), .maskReg(maskReg),
      .statusReg(statusReg)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   exp_t sbq[$];
   exp_t e;
   logic [15:0] act;
   logic chk = 1'b0;
   logic oePrev = 1'b0;
   int nChecks = 0;
   int nFails = 0;

   function automatic string kindName(int k);
      case (k)
         K_RD:   return "dbOut";
         K_MASK: return "mask";
         K_CMD:  return "command";
         K_STS:  return "status";
         K_REQ:  return "request";
         K_OE:   return "dbOe";
         K_ADDR: return "curAddr";
         K_CNT:  return "curCnt";
         K_MODE: return "mode";
         default: return "other";
      endcase
   endfunction

   function automatic logic [15:0] probe(int k, int ch);
      case (k)
         K_MASK: return {8'h00, maskReg};
         K_CMD:  return {8'h00, commandReg};
         K_STS:  return {8'h00, statusReg};
         K_REQ:  return {8'h00, requestReg};
         K_OE:   return {15'h0, cpu.DB_oe};
         K_ADDR: return cur_addr[ch];
         K_CNT:  return cur_cnt[ch];
         K_MODE: return {10'h0, modeReg[ch]};
         default: return 16'hxxxx;
      endcase
   endfunction

   always @(negedge CLK) begin
      if (!RESET && ((cpu.DB_oe && !oePrev) || chk)) begin
         nChecks++;
         if (sbq.size() == 0) begin
            nFails++;
            $display("FAIL unexpected: output with empty scoreboard, dbOut=%h", cpu.DB_out);
         end else begin
            e = sbq.pop_front();
            act = (e.kind == K_RD) ? {8'h00, cpu.DB_out} : probe(e.kind, e.ch);
            if (act !== e.exp) begin
               nFails++;
               $display("FAIL %s[%0d] @%0t: got %h, expected %h", kindName(e.kind), e.ch, $time, act, e.exp);
            end
         end
      end
      oePrev = cpu.DB_oe;
   end

   task automatic cyc(int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic expPush(int k, int ch, logic [15:0] v);
      exp_t x;
      x.kind = k; x.ch = ch; x.exp = v;
      sbq.push_back(x);
   endtask

   task automatic chkReg(int k, int ch, logic [15:0] v);
      expPush(k, ch, v);
      chk = 1'b1;
      cyc(1);
      chk = 1'b0;
   endtask

   task automatic wr(logic [3:0] a, logic [7:0] d, logic [3:0] tc);
      cpu.CS_N = 1'b0; cpu.A = a; cpu.DB_in = d; cpu.IOW_N = 1'b0;
      cyc(1);
      cpu.IOW_N = 1'b1; tc_set = tc;
      cyc(1);
      tc_set = '0; cpu.CS_N = 1'b1;
      cyc(1);
   endtask

   task automatic rd(logic [3:0] a, logic [7:0] v, logic [3:0] tc);
      cpu.CS_N = 1'b0; cpu.A = a;
      expPush(K_RD, 0, {8'h00, v});
      cpu.IOR_N = 1'b0;
      cyc(1);
      cpu.IOR_N = 1'b1; tc_set = tc;
      cyc(1);
      tc_set = '0; cpu.CS_N = 1'b1;
      cyc(1);
   endtask

   task automatic pulseTc(logic [3:0] v);
      tc_set = v;
      cyc(1);
      tc_set = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1);
   end

   initial begin
      RESET = 1'b1;
      cpu.CS_N = 1'b1; cpu.IOR_N = 1'b1; cpu.IOW_N = 1'b1; cpu.HLDA = 1'b0;
      cpu.A = '0; cpu.DB_in = '0;
      dreq_sts = '0; tc_set = '0; upd_en = 1'b0; upd_ch = '0;
      upd_addr = '0; upd_cnt = '0; reload = 1'b0;
      cyc(3);
      RESET = 1'b0;
      cyc(1);

      // reset state
      chkReg(K_MASK, 0, 16'h000F);
      chkReg(K_CMD, 0, 16'h0000);
      chkReg(K_STS, 0, 16'h0000);
      chkReg(K_OE, 0, 16'h0000);
      chkReg(K_REQ, 0, 16'h0000);

      // two-byte address/count through the byte pointer
      wr(4'h2, 8'h34, 4'h0); wr(4'h2, 8'h12, 4'h0);
      chkReg(K_ADDR, 1, 16'h1234);
      rd(4'h2, 8'h34, 4'h0); rd(4'h2, 8'h12, 4'h0);
      wr(4'h3, 8'h78, 4'h0); wr(4'h3, 8'h56, 4'h0);
      chkReg(K_CNT, 1, 16'h5678);

      // clear FF, then gated writes
      wr(4'hC, 8'h00, 4'h0);
      wr(4'h0, 8'hAA, 4'h0);
      chkReg(K_ADDR, 0, 16'h00AA);
      cpu.HLDA = 1'b1; wr(4'h0, 8'h55, 4'h0); cpu.HLDA = 1'b0;
      chkReg(K_ADDR, 0, 16'h00AA);
      wr(4'h0, 8'hBB, 4'h0);
      chkReg(K_ADDR, 0, 16'hBBAA);
      // HLDA rising mid-strobe, then strobe without chip select
      cpu.CS_N = 1'b0; cpu.A = 4'h0; cpu.DB_in = 8'h11; cpu.IOW_N = 1'b0;
      cyc(1); cpu.HLDA = 1'b1;
      cyc(1); cpu.IOW_N = 1'b1; cpu.HLDA = 1'b0;
      cyc(1); cpu.CS_N = 1'b1; cpu.DB_in = 8'h22; cpu.IOW_N = 1'b0;
      cyc(1); cpu.IOW_N = 1'b1;
      cyc(1);
      chkReg(K_ADDR, 0, 16'hBBAA);

      // timing-control updates and autoinit reload
      upd_en = 1'b1; upd_ch = 2'd2; upd_addr = 16'hBEEF; upd_cnt = 16'h0102;
      cyc(1); upd_en = 1'b0;
      chkReg(K_ADDR, 2, 16'hBEEF);
      chkReg(K_CNT, 2, 16'h0102);
      reload = 1'b1; upd_en = 1'b1;
      cyc(1); reload = 1'b0; upd_en = 1'b0;
      chkReg(K_ADDR, 2, 16'h0000);

      // command, request, mask
      wr(4'h8, 8'hC4, 4'h0);
      chkReg(K_CMD, 0, 16'h00C4);
      wr(4'h9, 8'h06, 4'h0); wr(4'h9, 8'h05, 4'h0);
      chkReg(K_REQ, 0, 16'h0006);
      wr(4'hE, 8'h00, 4'h0);
      chkReg(K_MASK, 0, 16'h0000);

      // TC on ch1 without autoinit
      dreq_sts = 4'h5;
      pulseTc(4'b0010);
      chkReg(K_STS, 0, 16'h0052);
      chkReg(K_MASK, 0, 16'h0002);
      chkReg(K_REQ, 0, 16'h0004);
      rd(4'h8, 8'h52, 4'h0);
      chkReg(K_STS, 0, 16'h0050);

      // TC on ch1 with autoinit
      wr(4'hB, 8'h55, 4'h0);
      chkReg(K_MODE, 1, 16'h0015);
      wr(4'hE, 8'h00, 4'h0);
      pulseTc(4'b0010);
      chkReg(K_MASK, 0, 16'h0000);
      rd(4'h8, 8'h52, 4'h0);

      // TC on ch2 coinciding with status-read trailing edge
      rd(4'h8, 8'h50, 4'b0100);
      chkReg(K_STS, 0, 16'h0054);
      chkReg(K_MASK, 0, 16'h0004);
      chkReg(K_REQ, 0, 16'h0000);

      // master clear mid-sequence, with a coinciding TC
      wr(4'h9, 8'h07, 4'h0);
      wr(4'h2, 8'h99, 4'h0);
      wr(4'hD, 8'h00, 4'b0001);
      chkReg(K_MASK, 0, 16'h000F);
      chkReg(K_CMD, 0, 16'h0000);
      chkReg(K_REQ, 0, 16'h0000);
      chkReg(K_STS, 0, 16'h0050);
      chkReg(K_MODE, 1, 16'h0000);
      rd(4'h2, 8'h99, 4'h0);

      // TC versus same-bit mask write
      wr(4'hA, 8'h01, 4'b0010);
      chkReg(K_MASK, 0, 16'h000F);
      chkReg(K_STS, 0, 16'h0052);
      wr(4'hF, 8'hF5, 4'h0);
      chkReg(K_MASK, 0, 16'h0005);

      // write-only / temp registers read as zero
      rd(4'h9, 8'h00, 4'h0);
      rd(4'hD, 8'h00, 4'h0);

      cyc(3);
      nChecks++;
      if (sbq.size() != 0) begin
         nFails++;
         $display("FAIL scoreboard drain: %0d entries left, expected 0", sbq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
